// File: rtl/icp_mem_arb.sv
// icp_mem_arb: two-requester memory arbiter (0 = host/loader, 1 = core).
// Round-robin on ties, one command per cycle, registered memory command
// port, and a two-deep read tag pipeline that routes returning read data
// back to its requester.
// Optional: define ICP_MEM_ARB_LOCK_EN to add i_lock[1:0] and a lock FSM
// that lets a requester own the memory for a sequence of commands.
module icp_mem_arb #(
  parameter int P_ADDR_W = 13,
  parameter int P_DATA_W = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_req_op   [2],
  input  logic [P_ADDR_W-1:0] i_req_addr [2],
  input  logic [P_DATA_W-1:0] i_req_data [2],
`ifdef ICP_MEM_ARB_LOCK_EN
  input  logic [1:0]          i_lock,
`endif
  output logic [1:0]          o_gnt,
  output logic [1:0]          o_rvalid,
  output logic [P_DATA_W-1:0] o_rdata,
  output logic [1:0]          o_op,
  output logic [P_ADDR_W-1:0] o_addr,
  output logic [P_DATA_W-1:0] o_data,
  input  logic [P_DATA_W-1:0] i_data
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  logic [1:0]          act;
  logic [1:0]          elig;
  logic                gnt_any;
  logic                gnt_sel;

  logic                r_last_q, r_last_d;
  logic [1:0]          o_op_q, o_op_d;
  logic [P_ADDR_W-1:0] o_addr_q, o_addr_d;
  logic [P_DATA_W-1:0] o_data_q, o_data_d;
  logic                rd1_v_q, rd1_v_d;
  logic                rd1_id_q, rd1_id_d;
  logic                rd2_v_q, rd2_v_d;
  logic                rd2_id_q, rd2_id_d;

`ifdef ICP_MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_OWN0 = 2'd1,
    LK_OWN1 = 2'd2
  } lock_e;

  lock_e lock_q, lock_d;
`endif

  // Request qualification and grant selection (round-robin on ties)
  always_comb begin
    act = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      act[n] = (i_req_op[n] == OP_READ) || (i_req_op[n] == OP_WRITE);
    end
    elig = act;
`ifdef ICP_MEM_ARB_LOCK_EN
    // An owner holding its lock excludes the other side even when idle itself
    if (lock_q == LK_OWN0 && i_lock[0]) elig = act & 2'b01;
    if (lock_q == LK_OWN1 && i_lock[1]) elig = act & 2'b10;
`endif
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (!i_rst) begin
      if (&elig) begin
        gnt_any = 1'b1;
        gnt_sel = ~r_last_q;
      end else if (elig[0]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end else if (elig[1]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
    end
    o_gnt = gnt_any ? (2'b01 << gnt_sel) : 2'b00;
  end

  // Next-state for the memory command register and read tag pipeline
  always_comb begin
    r_last_d = r_last_q;
    o_op_d   = OP_NONE;
    o_addr_d = o_addr_q;
    o_data_d = o_data_q;
    rd1_v_d  = 1'b0;
    rd1_id_d = rd1_id_q;
    rd2_v_d  = rd1_v_q;
    rd2_id_d = rd1_id_q;
    if (gnt_any) begin
      r_last_d = gnt_sel;
      o_op_d   = i_req_op[gnt_sel];
      o_addr_d = i_req_addr[gnt_sel];
      o_data_d = i_req_data[gnt_sel];
      rd1_v_d  = (i_req_op[gnt_sel] == OP_READ);
      rd1_id_d = gnt_sel;
    end
  end

`ifdef ICP_MEM_ARB_LOCK_EN
  // Lock FSM next-state: releasing owner frees the bus in the same cycle
  always_comb begin
    lock_d = lock_q;
    if (lock_q == LK_IDLE ||
        (lock_q == LK_OWN0 && !i_lock[0]) ||
        (lock_q == LK_OWN1 && !i_lock[1])) begin
      lock_d = LK_IDLE;
      if (gnt_any && i_lock[gnt_sel]) begin
        lock_d = gnt_sel ? LK_OWN1 : LK_OWN0;
      end
    end
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_q <= 1'b1;
      o_op_q   <= OP_NONE;
      o_addr_q <= '0;
      o_data_q <= '0;
      rd1_v_q  <= 1'b0;
      rd1_id_q <= 1'b0;
      rd2_v_q  <= 1'b0;
      rd2_id_q <= 1'b0;
`ifdef ICP_MEM_ARB_LOCK_EN
      lock_q   <= LK_IDLE;
`endif
    end else begin
      r_last_q <= r_last_d;
      o_op_q   <= o_op_d;
      o_addr_q <= o_addr_d;
      o_data_q <= o_data_d;
      rd1_v_q  <= rd1_v_d;
      rd1_id_q <= rd1_id_d;
      rd2_v_q  <= rd2_v_d;
      rd2_id_q <= rd2_id_d;
`ifdef ICP_MEM_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign o_op     = o_op_q;
  assign o_addr   = o_addr_q;
  assign o_data   = o_data_q;
  assign o_rdata  = i_data;
  assign o_rvalid = {rd2_v_q & rd2_id_q, rd2_v_q & ~rd2_id_q};

endmodule
